// File: rtl/cmp_pkg.sv
// Shared definitions for comparator-interface consumers: state encoding,
// flag bundle order {gt,lt,eq}, decoded relation and default operand width.
package cmp_pkg;

  localparam int CMP_WIDTH = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TEST   = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_flags_t;

  typedef enum logic [1:0] {
    REL_LT = 2'd0,
    REL_GT = 2'd1,
    REL_EQ = 2'd2
  } cmp_rel_t;

endpackage

// File: rtl/cmp_flag_check.sv
// Validates and decodes a comparator flag triple. onehot_ok is a strict
// (===) one-hot test; rel resolves eq > gt > lt, none asserted reads as lt.
module cmp_flag_check
  import cmp_pkg::*;
(
  input  logic     gt,
  input  logic     lt,
  input  logic     eq,
  output logic     onehot_ok,
  output cmp_rel_t rel
);

  cmp_flags_t flags;

  assign flags = '{gt: gt, lt: lt, eq: eq};

  assign onehot_ok = (flags === 3'b100) || (flags === 3'b010) || (flags === 3'b001);

  always_comb begin
    rel = REL_LT;
    if (eq)      rel = REL_EQ;
    else if (gt) rel = REL_GT;
  end

endmodule

// File: rtl/cmp_search.sv
// Successive-approximation search driving an external magnitude comparator.
// Optional strict flag checking is enabled by defining CMP_SEARCH_CHECK_EN.
module cmp_search
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] TOP_BIT = BW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] FIRST_PROBE = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]    state;
  logic [BW-1:0] bit_idx;
  logic          onehot_ok;
  cmp_rel_t      rel;

  cmp_flag_check u_check (
    .gt       (gt),
    .lt       (lt),
    .eq       (eq),
    .onehot_ok(onehot_ok),
    .rel      (rel)
  );

  assign busy = (state == S_TEST) || (state == S_VERIFY);
  assign done = (state == S_DONE);

`ifndef CMP_SEARCH_CHECK_EN
  logic unused_onehot;
  assign unused_onehot = onehot_ok;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_idx <= TOP_BIT;
      probe   <= '0;
      found   <= 1'b0;
      result  <= '0;
`ifdef CMP_SEARCH_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_TEST;
            probe   <= FIRST_PROBE;
            bit_idx <= TOP_BIT;
            found   <= 1'b0;
            result  <= '0;
`ifdef CMP_SEARCH_CHECK_EN
            err     <= 1'b0;
`endif
          end
        end
        S_TEST: begin
`ifdef CMP_SEARCH_CHECK_EN
          if (!onehot_ok) begin
            err    <= 1'b1;
            found  <= 1'b0;
            result <= probe;
            state  <= S_DONE;
          end else
`endif
          if (rel == REL_EQ) begin
            result <= probe;
            found  <= 1'b1;
            state  <= S_DONE;
          end else begin
            // gt clears the bit under test; lt leaves it set
            if (rel == REL_GT) probe[bit_idx] <= 1'b0;
            if (bit_idx != '0) begin
              probe[bit_idx - 1'b1] <= 1'b1;
              bit_idx <= bit_idx - 1'b1;
            end else begin
              state <= S_VERIFY;
            end
          end
        end
        S_VERIFY: begin
          result <= probe;
          state  <= S_DONE;
`ifdef CMP_SEARCH_CHECK_EN
          if (!onehot_ok) begin
            err   <= 1'b1;
            found <= 1'b0;
          end else
`endif
          if (rel == REL_EQ) begin
            found <= 1'b1;
          end else begin
            found <= 1'b0;
`ifdef CMP_SEARCH_CHECK_EN
            err   <= 1'b1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_search.sv
// Self-checking bench for cmp_search against a behavioural comparator and a
// closed-form model of the binary search (probe sequence, latency, result).
module tb_cmp_search;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         gt, lt, eq;
  logic [W-1:0] probe, result;
  logic         busy, done, found, err;

  logic [W-1:0] secret;
  logic         force_en;
  logic [2:0]   force_flags;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cmp_search #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .gt(gt), .lt(lt), .eq(eq),
    .probe(probe), .busy(busy), .done(done),
    .found(found), .err(err), .result(result)
  );

  always_comb begin
    if (force_en) {gt, lt, eq} = force_flags;
    else begin
      gt = (probe > secret);
      lt = (probe < secret);
      eq = (probe == secret);
    end
  end

  typedef struct {
    logic [W-1:0] sec;
    logic [W-1:0] exp_result;
    logic         exp_found;
    int           exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // k-th probe: secret's top k bits kept, next bit set as the trial bit
  function automatic logic [W-1:0] cand(input logic [W-1:0] s, input int k);
    logic [W-1:0] keep, trial;
    keep  = (k == 0) ? '0 : ~((W'(1) << (W - k)) - W'(1));
    trial = (k < W) ? (W'(1) << (W - 1 - k)) : '0;
    return (s & keep) | trial;
  endfunction

  // edges from start sampling to done: first k whose candidate equals the secret
  function automatic int model_lat(input logic [W-1:0] s);
    for (int k = 0; k < W; k++)
      if (cand(s, k) == s) return k + 1;
    return W + 1;
  endfunction

  task automatic run(input logic [W-1:0] s, input logic [W-1:0] exp_res,
                     input logic exp_fnd, input int exp_lat, input int pulse_at,
                     input bit start_in_done, input string tag);
    int lat;
    secret = s;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    lat = 0;
    while (!done && lat < 20) begin
      if (busy && !force_en) chk({tag, "_probe"}, probe, cand(s, lat));
      if (lat == pulse_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (lat == pulse_at + 1 && !done) chk({tag, "_busy_ignore"}, busy, 1);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_found"}, found, exp_fnd);
    if (start_in_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] s;
    vecs[0] = '{8'h80, 8'h80, 1'b1, 1};
    vecs[1] = '{8'h01, 8'h01, 1'b1, 8};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 9};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8};
    vecs[4] = '{8'h40, 8'h40, 1'b1, 2};
    vecs[5] = '{8'hA0, 8'hA0, 1'b1, 3};
    vecs[6] = '{8'h55, 8'h55, 1'b1, 8};

    rst = 1'b1; start = 1'b0; secret = '0; force_en = 1'b0; force_flags = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_probe", probe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run(vecs[i].sec, vecs[i].exp_result, vecs[i].exp_found, vecs[i].exp_lat,
          -1, 1'b0, $sformatf("vec%0d", i));

    // start pulsed mid-search and again in the done cycle: both ignored
    run(8'h01, 8'h01, 1'b1, 8, 3, 1'b0, "midstart");
    run(8'h3C, 8'h3C, 1'b1, 6, -1, 1'b1, "donestart");

    // asynchronous reset mid-search
    secret = 8'h00;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_probe", probe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_nodone", done, 0);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run(8'h37, 8'h37, 1'b1, 8, -1, 1'b0, "postrst");

`ifdef CMP_SEARCH_CHECK_EN
    foreach (vecs[i]) begin
      if (i < 2) begin
        secret = 8'h12;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        force_en = 1'b1;
        force_flags = (i == 0) ? 3'bxxx : 3'b110;
        @(posedge clk); #1;
        chk($sformatf("bad%0d_done", i), done, 1);
        chk($sformatf("bad%0d_err", i), err, 1);
        chk($sformatf("bad%0d_found", i), found, 0);
        chk($sformatf("bad%0d_result", i), result, 8'h80);
        force_en = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("bad%0d_idle", i), busy, 0);
      end
    end
`else
    // no flags at all read as lt; gt wins over lt; neither confirms eq
    force_en = 1'b1;
    force_flags = 3'b000;
    run(8'h00, 8'hFF, 1'b0, 9, -1, 1'b0, "none_lt");
    chk("none_lt_err", err, 0);
    force_flags = 3'b110;
    run(8'h00, 8'h00, 1'b0, 9, -1, 1'b0, "gt_prio");
    force_en = 1'b0;
`endif

    for (int r = 0; r < 40; r++) begin
      s = W'($urandom_range(0, 255));
      run(s, s, 1'b1, model_lat(s), -1, 1'b0, $sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_err", r), err, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
